key_debounce: RTL

//  Front-end conditioner for the stopwatch push-buttons (start/stop, pause, load).
//  - Synchronises raw asynchronous key pins to clk and rejects contact bounce.
//  - Emits one-clock press/release pulses and a clean level per key.
//  - key_press[i] feeds the edge-driven start/pause/load inputs of the key control stage,
//    so every physical press produces exactly one clean event.

---
 rtl/key_debounce.sv | 103 ++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser, per-key debounce counter, one-clock
// press/release pulses. Optional long-hold pulse is built when KEY_LONGPRESS_EN is defined.
module key_debounce #(
  parameter int N_KEYS         = 3,
  parameter int DEB_CYCLES     = 1000000,
  parameter int CNT_W          = 20,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LONG_CYCLES    = 50000000,
  parameter int LONG_W         = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_KEYS-1:0] key_norm;
  logic [N_KEYS-1:0] sync_1;
  logic [N_KEYS-1:0] sync_2;
  logic [N_KEYS-1:0] mismatch;
  logic [N_KEYS-1:0] accept;
  logic [CNT_W-1:0]  cnt [N_KEYS];

  // Internally 1 always means pressed, whatever the pin polarity.
  assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= key_norm;
      sync_2 <= sync_1;
    end
  end

  always_comb begin
    mismatch = '0;
    accept   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      mismatch[i] = sync_2[i] ^ key_level[i];
      accept[i]   = mismatch[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Any return to the current level restarts the count; acceptance also clears it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_KEYS; i++) begin
      if (rst || !mismatch[i] || accept[i]) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_level   <= key_level ^ accept;
      key_press   <= accept & sync_2;
      key_release <= accept & ~sync_2;
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam logic [LONG_W-1:0] HC_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] HC_DONE = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] hc [N_KEYS];

  // hc parks at HC_DONE after the pulse so a single hold fires only once.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_KEYS; i++) begin
      if (rst || !key_level[i]) begin
        hc[i]       <= '0;
        key_long[i] <= 1'b0;
      end else if (hc[i] == HC_LAST) begin
        hc[i]       <= HC_DONE;
        key_long[i] <= 1'b1;
      end else begin
        key_long[i] <= 1'b0;
        if (hc[i] != HC_DONE) begin
          hc[i] <= hc[i] + LONG_W'(1);
        end
      end
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^{LONG_CYCLES[0], LONG_W[0]};
  assign key_long        = '0;
`endif

endmodule
